// File: rtl/fm_pkg.sv
// ============================================================================
// Module   : fm_pkg
// Purpose  : Shared mode encoding, pipeline depth and sine quadrant decode.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fm_pkg;

    localparam logic [1:0] MODE_CW = 2'd0;
    localparam logic [1:0] MODE_FM = 2'd1;
    localparam logic [1:0] MODE_PM = 2'd2;

    localparam int LATENCY = 5;

    typedef struct packed {
        logic mirror;
        logic negate;
    } quad_t;

    // Quadrants 1 and 3 read the quarter table backwards; 2 and 3 are negated.
    function automatic quad_t quad_decode(input logic [1:0] quadrant);
        quad_t q;
        q.mirror = quadrant[0];
        q.negate = quadrant[1];
        return q;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sine_quarter_lut.sv
// ============================================================================
// Module   : sine_quarter_lut
// Purpose  : Registered, enable-gated full-wave sine from a quarter-wave table.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sine_quarter_lut
    import fm_pkg::*;
#(
    parameter int SINE_LOOKUP_WIDTH = 16,
    parameter int PHASE_WIDTH       = 12
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_ce,
    input  logic [PHASE_WIDTH-1:0]          i_phase,
    output logic signed [SINE_LOOKUP_WIDTH:0] o_sample
);

    localparam int  c_entries = 2 ** (PHASE_WIDTH - 2);
    localparam int  c_full    = 2 ** SINE_LOOKUP_WIDTH - 1;
    localparam real c_pi      = 3.14159265358979323846;

    logic [SINE_LOOKUP_WIDTH-1:0] w_table [c_entries + 1];

    // Entry c_entries holds 90 degrees so the mirrored read hits the exact peak.
    for (genvar k = 0; k <= c_entries; k++) begin : g_table
        localparam real c_s = $sin(c_pi * k / (2.0 * c_entries));
        localparam int  c_v = $rtoi(c_full * c_s + 0.5);
        assign w_table[k] = SINE_LOOKUP_WIDTH'(c_v);
    end

    quad_t                        w_quad;
    logic [PHASE_WIDTH-2:0]       w_offset;
    logic [PHASE_WIDTH-2:0]       w_index;
    logic [SINE_LOOKUP_WIDTH-1:0] w_mag;

    assign w_quad   = quad_decode(i_phase[PHASE_WIDTH-1 -: 2]);
    assign w_offset = {1'b0, i_phase[PHASE_WIDTH-3:0]};
    assign w_index  = w_quad.mirror ? ((PHASE_WIDTH-1)'(c_entries) - w_offset) : w_offset;
    assign w_mag    = w_table[w_index];

    always_ff @(posedge clk) begin
        if (rst) begin
            o_sample <= '0;
        end else if (i_ce) begin
            o_sample <= w_quad.negate ? -$signed({1'b0, w_mag}) : $signed({1'b0, w_mag});
        end
    end

endmodule

`default_nettype wire

// File: rtl/fm_iq_generator.sv
// ============================================================================
// Module   : fm_iq_generator
// Purpose  : Phase-continuous I/Q carrier with CW/FM/PM from a sine modulator.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fm_iq_generator
    import fm_pkg::*;
#(
    parameter int SINE_LOOKUP_WIDTH = 16,
    parameter int PHASE_WIDTH       = 12,
    parameter int ACCUMULATOR_WIDTH = 32
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic                               i_ce,
    input  logic                               i_update,
    input  logic [1:0]                         i_mode,
    input  logic [ACCUMULATOR_WIDTH-2:0]       carrier_center_increment,
    input  logic [ACCUMULATOR_WIDTH-2:0]       modulation_increment,
    input  logic [SINE_LOOKUP_WIDTH:0]         modulation_deviation_amount,
    output logic signed [SINE_LOOKUP_WIDTH:0]  o_i,
    output logic signed [SINE_LOOKUP_WIDTH:0]  o_q,
    output logic                               o_valid,
    output logic                               o_update_ack
);

    localparam int c_pm_shift = ACCUMULATOR_WIDTH - SINE_LOOKUP_WIDTH - 1;
    localparam int c_prod_w   = 2 * SINE_LOOKUP_WIDTH + 3;
    localparam logic [2:0] c_fill_full = 3'(LATENCY);
    localparam logic [PHASE_WIDTH-1:0] c_quarter = PHASE_WIDTH'(2 ** (PHASE_WIDTH - 2));

    logic [1:0]                        r_sh_mode, r_act_mode;
    logic [ACCUMULATOR_WIDTH-2:0]      r_sh_car, r_sh_mod, r_act_car, r_act_mod;
    logic [SINE_LOOKUP_WIDTH:0]        r_sh_dev, r_act_dev;
    logic                              r_pending, r_ack, r_valid;
    logic [ACCUMULATOR_WIDTH-1:0]      r_mod_acc, r_car_acc;
    logic signed [ACCUMULATOR_WIDTH-1:0] r_off;
    logic [2:0]                        r_fill;

    logic                              w_transfer;
    logic signed [SINE_LOOKUP_WIDTH:0] w_m;
    logic signed [c_prod_w-1:0]        w_prod;
    logic signed [ACCUMULATOR_WIDTH-1:0] w_off, w_fm_off, w_pm_off;
    logic [ACCUMULATOR_WIDTH-1:0]      w_p;
    logic [PHASE_WIDTH-1:0]            w_mod_phase, w_q_phase, w_i_phase;

    assign w_transfer = i_ce & r_pending;

    // Shadow/active configuration; a same-cycle update lands in the shadow after the transfer.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sh_mode  <= MODE_CW;
            r_sh_car   <= '0;
            r_sh_mod   <= '0;
            r_sh_dev   <= '0;
            r_act_mode <= MODE_CW;
            r_act_car  <= '0;
            r_act_mod  <= '0;
            r_act_dev  <= '0;
            r_pending  <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            r_ack <= w_transfer;
            if (w_transfer) begin
                r_act_mode <= r_sh_mode;
                r_act_car  <= r_sh_car;
                r_act_mod  <= r_sh_mod;
                r_act_dev  <= r_sh_dev;
            end
            if (i_update) begin
                r_sh_mode <= i_mode;
                r_sh_car  <= carrier_center_increment;
                r_sh_mod  <= modulation_increment;
                r_sh_dev  <= modulation_deviation_amount;
                r_pending <= 1'b1;
            end else if (w_transfer) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign w_prod    = c_prod_w'(w_m) * c_prod_w'($signed({1'b0, r_act_dev}));
    assign w_off     = ACCUMULATOR_WIDTH'(w_prod >>> SINE_LOOKUP_WIDTH);
    assign w_fm_off  = (r_act_mode == MODE_FM) ? r_off : '0;
    assign w_pm_off  = (r_act_mode == MODE_PM) ? (r_off <<< c_pm_shift) : '0;
    assign w_p       = r_car_acc + w_pm_off;

    assign w_mod_phase = PHASE_WIDTH'(r_mod_acc >> (ACCUMULATOR_WIDTH - PHASE_WIDTH));
    assign w_q_phase   = PHASE_WIDTH'(w_p >> (ACCUMULATOR_WIDTH - PHASE_WIDTH));
    assign w_i_phase   = w_q_phase + c_quarter;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mod_acc <= '0;
            r_car_acc <= '0;
            r_off     <= '0;
            r_fill    <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= i_ce && (r_fill == c_fill_full);
            if (i_ce) begin
                r_mod_acc <= r_mod_acc + {1'b0, r_act_mod};
                r_off     <= w_off;
                r_car_acc <= r_car_acc + {1'b0, r_act_car} + w_fm_off;
                if (r_fill != c_fill_full) begin
                    r_fill <= r_fill + 3'd1;
                end
            end
        end
    end

    sine_quarter_lut #(
        .SINE_LOOKUP_WIDTH (SINE_LOOKUP_WIDTH),
        .PHASE_WIDTH       (PHASE_WIDTH)
    ) u_mod_lut (
        .clk      (i_clk),
        .rst      (i_reset),
        .i_ce     (i_ce),
        .i_phase  (w_mod_phase),
        .o_sample (w_m)
    );

    sine_quarter_lut #(
        .SINE_LOOKUP_WIDTH (SINE_LOOKUP_WIDTH),
        .PHASE_WIDTH       (PHASE_WIDTH)
    ) u_q_lut (
        .clk      (i_clk),
        .rst      (i_reset),
        .i_ce     (i_ce),
        .i_phase  (w_q_phase),
        .o_sample (o_q)
    );

    sine_quarter_lut #(
        .SINE_LOOKUP_WIDTH (SINE_LOOKUP_WIDTH),
        .PHASE_WIDTH       (PHASE_WIDTH)
    ) u_i_lut (
        .clk      (i_clk),
        .rst      (i_reset),
        .i_ce     (i_ce),
        .i_phase  (w_i_phase),
        .o_sample (o_i)
    );

    assign o_valid      = r_valid;
    assign o_update_ack = r_ack;

endmodule

`default_nettype wire

// File: tb/tb_fm_iq_generator.sv
// ============================================================================
// Module   : tb_fm_iq_generator
// Purpose  : Directed plus random stimulus against a behavioural I/Q model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fm_iq_generator;

    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, ce, upd;
    logic [1:0]         mode;
    logic [30:0]        cinc, minc;
    logic [16:0]        dev;
    logic signed [16:0] o_i, o_q;
    logic               o_valid, o_ack;

    fm_iq_generator #(
        .SINE_LOOKUP_WIDTH (16),
        .PHASE_WIDTH       (12),
        .ACCUMULATOR_WIDTH (32)
    ) dut (
        .i_clk                       (clk),
        .i_reset                     (rst),
        .i_ce                        (ce),
        .i_update                    (upd),
        .i_mode                      (mode),
        .carrier_center_increment    (cinc),
        .modulation_increment        (minc),
        .modulation_deviation_amount (dev),
        .o_i                         (o_i),
        .o_q                         (o_q),
        .o_valid                     (o_valid),
        .o_update_ack                (o_ack)
    );

    int n_vec = 0;
    int n_err = 0;
    int acks;

    // Behavioural model state
    bit [1:0]  s_mode, a_mode;
    bit [30:0] s_c, s_m, a_c, a_m;
    bit [16:0] s_d, a_d;
    bit        pend;
    bit [31:0] mod_acc, car_acc;
    longint    m, off;
    int        fill;
    logic signed [16:0] e_i, e_q;
    logic      e_v, e_a;

    // Rounded sine of the top 12 phase bits, folded by half-turn symmetry.
    function automatic longint ref_sin(input bit [31:0] p);
        int     k, a;
        real    s;
        longint v;
        k = int'(p >> 20);
        a = k % 2048;
        if (a > 1024) a = 2048 - a;
        s = $sin(PI * a / 2048.0);
        v = longint'($floor(65535.0 * s + 0.5));
        return (k >= 2048) ? -v : v;
    endfunction

    task automatic model_step();
        bit        xfer;
        bit [31:0] p;
        longint    d, n_m, n_off;
        if (rst) begin
            s_mode = 0; a_mode = 0; s_c = 0; s_m = 0; a_c = 0; a_m = 0;
            s_d = 0; a_d = 0; pend = 0; mod_acc = 0; car_acc = 0;
            m = 0; off = 0; fill = 0;
            e_i = 0; e_q = 0; e_v = 0; e_a = 0;
        end else begin
            xfer = ce && pend;
            e_a  = xfer;
            e_v  = ce && (fill == 5);
            if (ce) begin
                d     = longint'(a_d);
                p     = car_acc + ((a_mode == 2'd2) ? 32'(off <<< 15) : 32'd0);
                e_q   = 17'(ref_sin(p));
                e_i   = 17'(ref_sin(p + 32'h4000_0000));
                n_m   = ref_sin(mod_acc);
                n_off = (m * d) >>> 16;
                car_acc = car_acc + {1'b0, a_c} + ((a_mode == 2'd1) ? 32'(off) : 32'd0);
                mod_acc = mod_acc + {1'b0, a_m};
                m   = n_m;
                off = n_off;
                if (fill < 5) fill++;
            end
            if (xfer) begin
                a_mode = s_mode; a_c = s_c; a_m = s_m; a_d = s_d;
            end
            if (upd) begin
                s_mode = mode; s_c = cinc; s_m = minc; s_d = dev; pend = 1;
            end else if (xfer) begin
                pend = 0;
            end
        end
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        n_vec++;
        assert ({o_i, o_q, o_valid, o_ack} === {e_i, e_q, e_v, e_a})
        else begin
            n_err++;
            $error("FAIL %s: got i=%0d q=%0d v=%0b ack=%0b, expected i=%0d q=%0d v=%0b ack=%0b",
                   tag, o_i, o_q, o_valid, o_ack, e_i, e_q, e_v, e_a);
        end
    endtask

    task automatic load(input logic [1:0] md, input logic [30:0] c, input logic [30:0] mi,
                        input logic [16:0] d);
        mode = md; cinc = c; minc = mi; dev = d; upd = 1'b1;
        step("load");
        upd = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        n_vec++;
        assert ({o_i, o_q, o_valid, o_ack} === 36'd0)
        else begin
            n_err++;
            $error("FAIL %s: got i=%0d q=%0d v=%0b ack=%0b, expected all zero",
                   tag, o_i, o_q, o_valid, o_ack);
        end
    endtask

    task automatic check_acks(input string tag, input int want);
        n_vec++;
        assert (acks === want)
        else begin
            n_err++;
            $error("FAIL %s: got %0d acks, expected %0d", tag, acks, want);
        end
    endtask

    initial begin
        bit card;

        // Reset dominates enable and update
        rst = 1'b1; ce = 1'b1; upd = 1'b1;
        mode = 2'd1; cinc = 31'($urandom); minc = 31'($urandom); dev = 17'($urandom);
        repeat (3) step("reset");
        check_zero("reset_zero");
        rst = 1'b0; upd = 1'b0;
        acks = 0;
        repeat (8) begin step("post_reset"); acks += int'(o_ack); end
        check_acks("no_spurious_ack", 0);

        // CW quarter-turn carrier
        load(2'd0, 31'h4000_0000, 31'd0, 17'd0);
        repeat (10) step("cw");
        repeat (8) begin
            step("cw");
            card = ((o_i === 17'sd0) && ((o_q === 17'sd65535) || (o_q === -17'sd65535))) ||
                   ((o_q === 17'sd0) && ((o_i === 17'sd65535) || (o_i === -17'sd65535)));
            n_vec++;
            assert ({card, o_valid} === 2'b11)
            else begin
                n_err++;
                $error("FAIL cw_cardinal: got i=%0d q=%0d v=%0b, expected a cardinal point with v=1",
                       o_i, o_q, o_valid);
            end
        end

        // FM long run for phase continuity
        load(2'd1, 31'h1000_0000, 31'h4000_0000, 17'h10000);
        repeat (10000) step("fm");

        // PM with a stationary carrier
        load(2'd2, 31'd0, 31'h4000_0000, 17'h10000);
        repeat (40) step("pm");

        // Enable gaps with an update inside the gap
        ce = 1'b1; step("gap");
        ce = 1'b0; mode = 2'd1; cinc = 31'h0123_4567; minc = 31'h0020_0000; dev = 17'd30000;
        upd = 1'b1; step("gap");
        upd = 1'b0; step("gap");
        ce = 1'b1; step("gap");
        repeat (6) step("gap");

        // Two updates while pending collapse into one ack
        ce = 1'b0; mode = 2'd2; cinc = 31'h0700_0000; upd = 1'b1; step("pend");
        mode = 2'd1; cinc = 31'h0300_0000; minc = 31'h0100_0000; dev = 17'd50000; step("pend");
        upd = 1'b0; ce = 1'b1; acks = 0;
        repeat (6) begin step("pend"); acks += int'(o_ack); end
        check_acks("single_ack", 1);

        // Update coinciding with a transfer yields a second ack
        acks = 0;
        mode = 2'd0; cinc = 31'h0400_0000; upd = 1'b1; step("dbl"); acks += int'(o_ack);
        mode = 2'd1; cinc = 31'h0200_0000; step("dbl"); acks += int'(o_ack);
        upd = 1'b0;
        repeat (3) begin step("dbl"); acks += int'(o_ack); end
        check_acks("double_ack", 2);

        // Reset mid-stream in FM
        load(2'd1, 31'h0800_0000, 31'h0400_0000, 17'd65536);
        repeat (20) step("fm2");
        rst = 1'b1; step("mid_reset");
        check_zero("mid_reset_zero");
        rst = 1'b0;
        repeat (10) step("reprime");

        // Random traffic
        repeat (3000) begin
            ce  = ($urandom_range(0, 3) != 0);
            upd = ($urandom_range(0, 19) == 0);
            if (upd) begin
                mode = 2'($urandom); cinc = 31'($urandom);
                minc = 31'($urandom); dev = 17'($urandom);
            end
            rst = ($urandom_range(0, 499) == 0);
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
